// File: rtl/reg_wb_pipe.sv
// reg_wb_pipe: MEM->WB pipeline register with skid buffer, flush, x0 guard and writeback forwarding
module reg_wb_pipe #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int ZERO_GUARD = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              in_we,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_we,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  drop_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [ADDR_W-1:0] main_addr, skid_addr;
  logic main_we, skid_we, cap_we;
  logic accept, pop, ld_main_in, ld_main_skid, ld_skid;
  logic main_hit, skid_hit;
  logic [1:0] held;
  logic [CNT_W:0] drop_sum;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign accept    = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign cap_we    = in_we & ~((ZERO_GUARD != 0) & (in_addr == '0));
  assign out_data  = main_data;
  assign out_addr  = main_addr;
  assign out_we    = out_valid & main_we;
  assign main_hit  = out_valid & main_we & (main_addr == fwd_addr) & (|fwd_addr);
  assign skid_hit  = (state == FULL) & skid_we & (skid_addr == fwd_addr) & (|fwd_addr);
  assign fwd_hit   = main_hit | skid_hit;
  assign fwd_data  = skid_hit ? skid_data : main_hit ? main_data : '0;
  assign held      = (state == FULL) ? 2'd2 : (state == ONE) ? 2'd1 : 2'd0;
  assign drop_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(held);
  always_comb begin
    ld_main_in   = accept & ((state == EMPTY) | ((state == ONE) & pop));
    ld_main_skid = (state == FULL) & pop;
    ld_skid      = (state == ONE) & accept & ~pop;
    state_nxt    = flush ? EMPTY :
                   (state == EMPTY) ? (accept ? ONE : EMPTY) :
                   (state == ONE) ? (accept & ~pop ? FULL : ~accept & pop ? EMPTY : ONE) :
                   (pop ? ONE : FULL);
  end
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else state <= state_nxt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data <= '0;
      main_addr <= '0;
      main_we   <= 1'b0;
      skid_data <= '0;
      skid_addr <= '0;
      skid_we   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (ld_main_in) begin
        main_data <= in_data;
        main_addr <= in_addr;
        main_we   <= cap_we;
      end else if (ld_main_skid) begin
        main_data <= skid_data;
        main_addr <= skid_addr;
        main_we   <= skid_we;
      end
      if (ld_skid) begin
        skid_data <= in_data;
        skid_addr <= in_addr;
        skid_we   <= cap_we;
      end
      if (flush) drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_reg_wb_pipe.sv
// tb_reg_wb_pipe: directed self-checking bench for reg_wb_pipe
module tb_reg_wb_pipe;
  logic clk = 1'b0;
  logic reset, flush, in_valid, in_we, out_ready;
  logic [31:0] in_data;
  logic [4:0] in_addr, fwd_addr;
  logic in_ready, out_valid, out_we, fwd_hit;
  logic [31:0] out_data, fwd_data;
  logic [4:0] out_addr;
  logic [1:0] drop_cnt;
  logic g_in_ready, g_out_valid, g_out_we, g_fwd_hit;
  logic [31:0] g_out_data, g_fwd_data;
  logic [4:0] g_out_addr;
  logic [15:0] g_drop_cnt;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  reg_wb_pipe #(.DATA_W(32), .ADDR_W(5), .ZERO_GUARD(1), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr), .in_we(in_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr), .out_we(out_we),
    .fwd_addr(fwd_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .drop_cnt(drop_cnt)
  );
  reg_wb_pipe #(.DATA_W(32), .ADDR_W(5), .ZERO_GUARD(0), .CNT_W(16)) dut_g0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(g_in_ready), .in_data(in_data), .in_addr(in_addr), .in_we(in_we),
    .out_valid(g_out_valid), .out_ready(out_ready), .out_data(g_out_data), .out_addr(g_out_addr), .out_we(g_out_we),
    .fwd_addr(fwd_addr), .fwd_hit(g_fwd_hit), .fwd_data(g_fwd_data), .drop_cnt(g_drop_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [31:0] d, input logic [4:0] a, input logic w);
    in_valid = 1'b1;
    in_data  = d;
    in_addr  = a;
    in_we    = w;
  endtask
  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_we = 1'b0; out_ready = 1'b0;
    in_data = '0; in_addr = '0; fwd_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_we", out_we, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    fwd_addr = 5'd3;
    #1;
    chk("rst_fwd_hit_r3", fwd_hit, 0);
    out_ready = 1'b1;
    offer(32'hA5A5_0001, 5'd3, 1'b1);
    tick();
    chk("st1_valid", out_valid, 1);
    chk("st1_data", out_data, 32'hA5A5_0001);
    chk("st1_addr", out_addr, 3);
    chk("st1_we", out_we, 1);
    chk("st1_in_ready", in_ready, 1);
    chk("st1_fwd_hit", fwd_hit, 1);
    chk("st1_fwd_data", fwd_data, 32'hA5A5_0001);
    offer(32'h0000_0002, 5'd4, 1'b1);
    tick();
    chk("st2_data", out_data, 2);
    chk("st2_addr", out_addr, 4);
    chk("st2_in_ready", in_ready, 1);
    chk("st2_fwd_miss", fwd_hit, 0);
    in_valid = 1'b0;
    tick();
    chk("st_drain_valid", out_valid, 0);
    chk("st_drain_we", out_we, 0);
    out_ready = 1'b0;
    offer(32'h11, 5'd1, 1'b1);
    tick();
    chk("bp1_in_ready", in_ready, 1);
    chk("bp1_data", out_data, 32'h11);
    offer(32'h22, 5'd2, 1'b1);
    tick();
    chk("bp2_in_ready", in_ready, 0);
    chk("bp2_data", out_data, 32'h11);
    offer(32'h33, 5'd5, 1'b1);
    tick();
    chk("bp3_in_ready", in_ready, 0);
    chk("bp3_data", out_data, 32'h11);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp4_data", out_data, 32'h22);
    chk("bp4_addr", out_addr, 2);
    chk("bp4_in_ready", in_ready, 1);
    tick();
    chk("bp5_valid", out_valid, 0);
    out_ready = 1'b0;
    offer(32'hDEAD_BEEF, 5'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("x0_valid", out_valid, 1);
    chk("x0_data", out_data, 32'hDEAD_BEEF);
    chk("x0_addr", out_addr, 0);
    chk("x0_we", out_we, 0);
    chk("x0_g0_we", g_out_we, 1);
    fwd_addr = 5'd0;
    #1;
    chk("x0_fwd_hit", fwd_hit, 0);
    chk("x0_g0_fwd_hit", g_fwd_hit, 0);
    chk("x0_g0_fwd_data", g_fwd_data, 0);
    out_ready = 1'b1;
    tick();
    chk("x0_drain", out_valid, 0);
    out_ready = 1'b0;
    offer(32'h10, 5'd7, 1'b1);
    tick();
    offer(32'h20, 5'd7, 1'b1);
    tick();
    in_valid = 1'b0;
    fwd_addr = 5'd7;
    #1;
    chk("fp_full", in_ready, 0);
    chk("fp_hit", fwd_hit, 1);
    chk("fp_data_skid", fwd_data, 32'h20);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fp_pop_head", out_data, 32'h20);
    chk("fp_pop_hit", fwd_hit, 1);
    chk("fp_pop_data", fwd_data, 32'h20);
    offer(32'h40, 5'd9, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("fp_main_only", fwd_data, 32'h20);
    fwd_addr = 5'd9;
    #1;
    chk("fp_skid_only", fwd_data, 32'h40);
    fwd_addr = 5'd6;
    #1;
    chk("fp_miss_data", fwd_data, 0);
    offer(32'h55, 5'd6, 1'b1);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("fl1_valid", out_valid, 0);
    chk("fl1_in_ready", in_ready, 1);
    chk("fl1_drop", drop_cnt, 2);
    chk("fl1_g0_drop", g_drop_cnt, 2);
    chk("fl1_held_data", out_data, 32'h20);
    chk("fl1_fwd_hit", fwd_hit, 0);
    tick();
    chk("fl1_no_accept", out_valid, 0);
    offer(32'h66, 5'd1, 1'b1);
    tick();
    flush = 1'b1;
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
    chk("fl2_drop", drop_cnt, 3);
    chk("fl2_g0_drop", g_drop_cnt, 3);
    offer(32'h77, 5'd1, 1'b1);
    tick();
    offer(32'h88, 5'd2, 1'b1);
    tick();
    chk("fl3_full", in_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl3_sat", drop_cnt, 3);
    chk("fl3_g0_drop", g_drop_cnt, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_drop0", drop_cnt, 0);
    offer(32'h99, 5'd3, 1'b1);
    tick();
    flush = 1'b1;
    in_valid = 1'b0;
    tick();
    flush = 1'b0;
    chk("mr_drop1", drop_cnt, 1);
    offer(32'hAB, 5'd3, 1'b1);
    tick();
    in_valid = 1'b0;
    fwd_addr = 5'd3;
    #1;
    chk("mr_one", out_valid, 1);
    chk("mr_fwd_pre", fwd_hit, 1);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    chk("mr_in_ready", in_ready, 1);
    chk("mr_out_valid", out_valid, 0);
    chk("mr_out_data", out_data, 0);
    chk("mr_out_addr", out_addr, 0);
    chk("mr_out_we", out_we, 0);
    chk("mr_fwd_hit", fwd_hit, 0);
    chk("mr_fwd_data", fwd_data, 0);
    chk("mr_drop", drop_cnt, 0);
    chk("mr_g0_drop", g_drop_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/reg_wb_pipe.md
# reg_wb_pipe

Parametrised MEM→WB pipeline register with valid/ready flow control, a two-entry skid buffer, synchronous flush, x0 write suppression and a writeback forwarding port. It sits between the memory stage and the register-file write port. It lets a stalled writeback back-pressure the memory stage without any combinational ready path. It also counts valid entries discarded by flushes for performance debug.

## Interface
Parameters:
- DATA_W, 32, writeback data width
- ADDR_W, 5, destination register index width
- ZERO_GUARD, 1, when 1 an entry with addr==0 is captured with we=0
- CNT_W, 16, width of the flush-drop counter

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; highest priority
- flush  in  1  discard all held entries and the input offered this cycle
- in_valid  in  1  memory stage offers an entry
- in_ready  out  1  block can accept; depends on state only
- in_data  in  DATA_W  result (load data or ALU result)
- in_addr  in  ADDR_W  destination register
- in_we  in  1  entry writes the register file
- out_valid  out  1  head entry present
- out_ready  in  1  register file consumes the head this cycle
- out_data  out  DATA_W  head data
- out_addr  out  ADDR_W  head destination
- out_we  out  1  head write enable, forced 0 when out_valid=0
- fwd_addr  in  ADDR_W  source register queried by the hazard unit
- fwd_hit  out  1  a held entry will write fwd_addr
- fwd_data  out  DATA_W  data of the newest matching entry, 0 on miss
- drop_cnt  out  CNT_W  saturating count of valid entries discarded by flush

## Operation
- Storage: main entry (head) and skid entry, each {data, addr, we}.
- States: EMPTY, ONE (main valid), FULL (main and skid valid).
- in_ready = (state != FULL). out_valid = (state != EMPTY).
- accept = in_valid & in_ready & !flush. pop = out_valid & out_ready & !flush.
- EMPTY:
  - accept → main←in, state ONE.
- ONE:
  - accept & !pop → skid←in, FULL.
  - accept & pop → main←in, ONE.
  - pop only → EMPTY.
  - neither → hold.
- FULL:
  - pop → main←skid, ONE.
  - otherwise hold. in_valid is ignored.
- Capture rule: stored we = in_we & !(ZERO_GUARD & in_addr==0). data and addr are stored unmodified.
- Flush (reset=0): state←EMPTY; the input is not accepted.
  - drop_cnt += number of valid held entries (0, 1 or 2), saturating at 2^CNT_W−1.
  - The offered input is not counted.
  - Entry data/addr/we fields hold their previous values. Only state changes.
- out_data/out_addr show the main entry regardless of out_valid. Consumers must qualify with out_valid.
- Forwarding (combinational from stored state):
  - An entry hits when valid & we & addr==fwd_addr & fwd_addr!=0.
  - The skid entry is newer than main. If both hit, fwd_data = skid data.
  - fwd_hit = OR of the hits.
  - fwd_addr==0 never hits, regardless of ZERO_GUARD.
- Reset: state EMPTY, all entry fields 0, drop_cnt 0.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_addr=0, out_we=0, fwd_hit=0, fwd_data=0, drop_cnt=0.
- Latency: an entry accepted at edge N is on out_* with out_valid=1 after edge N.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- in_ready falls the cycle after a back-pressured accept fills the skid. An input offered while FULL is not taken.
- No combinational path from out_ready or in_valid to in_ready.
- Paths from fwd_addr to fwd_hit/fwd_data are combinational (single compare + mux).
- Priority: reset > flush > accept/pop.
- Simultaneous flush and out_ready: no pop occurs. The head is dropped and counted.
- Reset asserted mid-operation clears everything at the next edge and does not touch drop_cnt except clearing it.

## Test plan
- Streaming: out_ready=1; feed (0xA5A5_0001, r3, we=1) then (0x0000_0002, r4, we=1) on consecutive cycles → each appears one cycle later, in_ready stays 1, state never FULL.
- Back-pressure: out_ready=0; accept (0x11, r1), then (0x22, r2) → in_ready=0 the following cycle; a third offer (0x33, r5) is not taken. Raise out_ready → outputs 0x11, 0x22 in order, then in_ready=1.
- x0 guard: accept (0xDEAD_BEEF, r0, we=1) with ZERO_GUARD=1 → out_we=0 with out_addr=0. Query fwd_addr=0 → fwd_hit=0.
- Forward priority: FULL with main (0x10, r7, we=1) and skid (0x20, r7, we=1); fwd_addr=7 → fwd_hit=1, fwd_data=0x20. Pop once → fwd_data=0x20 from the new main.
- Flush: FULL state plus in_valid=1 and out_ready=1, assert flush → next cycle out_valid=0, in_ready=1, drop_cnt=2. No entry consumed, input dropped. Repeat the flush with CNT_W=2 → drop_cnt saturates at 3.
- Reset mid-stream: state ONE with drop_cnt=1, assert reset → all outputs at reset values next cycle. A flush asserted in the same cycle has no effect.
